code_patch_fetch: RTL and testbench

- Upstream loader for the code patch core. Pulls patch entries bit-serially from the serial interface (SI) and writes each completed entry into the core's patch table (ENTRY_W bits, NUM_ENTRIES entries).
- Drives the SI read request. Signals table-complete through pat_gen_en_o, which gates the core's pattern-generation enable.
- Aborts cleanly on config drop or SI stall.

---
 rtl/code_patch_fetch.sv | 187 ++++++++++++++++++
 tb/tb_code_patch_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_patch_fetch.sv
// Bit-serial patch-table loader: shifts ENTRY_W-bit entries in from the SI, writes
// NUM_ENTRIES of them into the patch table, then raises pattern-generation enable.
module code_patch_fetch #(
    parameter int NUM_ENTRIES = 3,
    parameter int ENTRY_W     = 22,
    parameter int TIMEOUT     = 200,
    parameter int TO_W        = 8,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int BIT_W      = $clog2(ENTRY_W + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               cfg_pat_gen_i,
    output logic               si_read_o,
    input  logic               si_valid_i,
    input  logic               si_data_i,
    output logic               entry_wr_o,
    output logic [IDX_W-1:0]   entry_idx_o,
    output logic [ENTRY_W-1:0] entry_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               pat_gen_en_o,
    output logic               err_timeout_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        STORE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    // Only ENTRY_W-1 bits are kept: the final bit is merged straight into the write word.
    logic [ENTRY_W-2:0] shift_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [TO_W-1:0]    stall_r;
    logic [IDX_W-1:0]   wr_idx_r;
    logic [ENTRY_W-1:0] wr_data_r;
    logic               pat_gen_en_r;
    logic               last_bit_s;
    logic               last_idx_s;
    logic               stall_hit_s;

    assign last_bit_s  = (bit_cnt_r == BIT_W'(ENTRY_W - 1));
    assign last_idx_s  = (idx_r == IDX_W'(NUM_ENTRIES - 1));
    assign stall_hit_s = (stall_r == TO_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a dropped config wins over every other event.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i && cfg_pat_gen_i) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (!cfg_pat_gen_i) begin
                    state_s = IDLE;
                end else if (si_valid_i && last_bit_s) begin
                    state_s = STORE;
                end else if (!si_valid_i && stall_hit_s) begin
                    state_s = ERR;
                end else begin
                    state_s = SHIFT;
                end
            end
            STORE: begin
                if (!cfg_pat_gen_i) begin
                    state_s = IDLE;
                end else if (last_idx_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE, ERR: begin
                if (!cfg_pat_gen_i) begin
                    state_s = IDLE;
                end else if (start_i) begin
                    state_s = SHIFT;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Shift path, counters and the held write word/index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_r      <= {(ENTRY_W-1){1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            stall_r      <= {TO_W{1'b0}};
            wr_idx_r     <= {IDX_W{1'b0}};
            wr_data_r    <= {ENTRY_W{1'b0}};
            pat_gen_en_r <= 1'b0;
        end else begin
            pat_gen_en_r <= (state_s == DONE);
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (state_s == SHIFT) begin
                        bit_cnt_r <= {BIT_W{1'b0}};
                        idx_r     <= {IDX_W{1'b0}};
                        stall_r   <= {TO_W{1'b0}};
                    end
                end
                SHIFT: begin
                    if (cfg_pat_gen_i && si_valid_i) begin
                        shift_r   <= {shift_r[ENTRY_W-3:0], si_data_i};
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        stall_r   <= {TO_W{1'b0}};
                    end else if (cfg_pat_gen_i) begin
                        stall_r   <= stall_r + TO_W'(1);
                    end
                    // Write word only changes on entry to STORE, so it never moves while idle.
                    if (state_s == STORE) begin
                        wr_data_r <= {shift_r, si_data_i};
                        wr_idx_r  <= idx_r;
                    end
                end
                STORE: begin
                    if (state_s == SHIFT) begin
                        idx_r     <= idx_r + IDX_W'(1);
                        bit_cnt_r <= {BIT_W{1'b0}};
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    // Output decode; the write strobe is suppressed in the same cycle config drops.
    always_comb begin
        si_read_o     = 1'b0;
        entry_wr_o    = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        err_timeout_o = 1'b0;
        case (state_r)
            SHIFT: begin
                si_read_o = 1'b1;
                busy_o    = 1'b1;
            end
            STORE: begin
                entry_wr_o = cfg_pat_gen_i;
                busy_o     = 1'b1;
            end
            DONE: begin
                done_o = 1'b1;
            end
            ERR: begin
                err_timeout_o = 1'b1;
            end
            default: begin
                si_read_o = 1'b0;
            end
        endcase
    end

    assign entry_idx_o  = wr_idx_r;
    assign entry_data_o = wr_data_r;
    assign pat_gen_en_o = pat_gen_en_r;

endmodule

// File: tb/tb_code_patch_fetch.sv
// Scoreboard bench for code_patch_fetch: a serial source feeds three known entries,
// expected table writes are queued per load and checked by an independent monitor.
module tb_code_patch_fetch;

    localparam int EW = 22;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          cfg_pat_gen_i;
    logic          si_read_o;
    logic          si_valid_i;
    logic          si_data_i;
    logic          entry_wr_o;
    logic [1:0]    entry_idx_o;
    logic [EW-1:0] entry_data_o;
    logic          busy_o;
    logic          done_o;
    logic          pat_gen_en_o;
    logic          err_timeout_o;

    code_patch_fetch dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .cfg_pat_gen_i (cfg_pat_gen_i),
        .si_read_o     (si_read_o),
        .si_valid_i    (si_valid_i),
        .si_data_i     (si_data_i),
        .entry_wr_o    (entry_wr_o),
        .entry_idx_o   (entry_idx_o),
        .entry_data_o  (entry_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pat_gen_en_o  (pat_gen_en_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            idx;
        logic [EW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [EW-1:0] words [0:2] = '{22'h3ABCDE, 22'h012345, 22'h2AAAAA};
    int            edge_cnt = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            bit_ptr  = 0;
    int            src_mode = 0;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    function automatic logic get_bit(input int p);
        if (p >= 0 && p < 3 * EW) return words[p / EW][EW - 1 - (p % EW)];
        else return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // SI source: mode 0 always valid, mode 1 valid every other SHIFT cycle, mode 2 never valid.
    initial begin : src
        logic took;
        logic phase;
        took = 1'b0;
        phase = 1'b0;
        si_valid_i = 1'b0;
        si_data_i = 1'b0;
        forever begin
            @(negedge clk_i);
            took = si_read_o && si_valid_i;
            @(posedge clk_i);
            #2;
            if (took) bit_ptr++;
            if (si_read_o) begin
                case (src_mode)
                    0: si_valid_i = 1'b1;
                    1: begin si_valid_i = phase; phase = ~phase; end
                    default: si_valid_i = 1'b0;
                endcase
            end else begin
                phase = 1'b0;
                si_valid_i = 1'b0;
            end
            si_data_i = get_bit(bit_ptr);
        end
    end

    // Monitor: pops the scoreboard on every strobe and checks idx/data stay put otherwise.
    logic [31:0] prev_hold;
    logic        prev_ok = 1'b0;
    exp_t        mon_e;
    always @(negedge clk_i) begin
        if (entry_wr_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got idx %0d data %0h expected no write (cycle %0d)",
                         entry_idx_o, entry_data_o, edge_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_idx", 32'(entry_idx_o), 32'(mon_e.idx));
                chk("wr_data", 32'(entry_data_o), 32'(mon_e.data));
                chk("wr_cycle", 32'(edge_cnt), 32'(mon_e.cyc));
                chk("no_read_in_store", 32'(si_read_o), 32'd0);
            end
        end else if (rst_ni && prev_ok) begin
            chk("idx_data_hold", {8'd0, entry_idx_o, entry_data_o}, prev_hold);
        end
        prev_hold = {8'd0, entry_idx_o, entry_data_o};
        prev_ok = rst_ni;
    end

    task automatic drive_at(input int target);
        while (edge_cnt < target) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_at(input int target);
        while (edge_cnt < target) begin
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
    endtask

    task automatic start_load(input int mode, output int e);
        @(posedge clk_i);
        #1;
        src_mode = mode;
        bit_ptr = 0;
        start_i = 1'b1;
        e = edge_cnt;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic push_load(input int e, input int step, input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.idx = i;
            x.data = words[i];
            x.cyc = e + step * (i + 1);
            sb_q.push_back(x);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {3'd0, si_read_o, entry_wr_o, entry_idx_o, entry_data_o,
                busy_o, done_o, pat_gen_en_o, err_timeout_o};
    endfunction

    initial begin : main
        int e;
        rst_ni = 1'b0;
        start_i = 1'b0;
        cfg_pat_gen_i = 1'b0;
        check_at(2);
        chk("reset_outputs", all_outs(), 32'd0);
        drive_at(4);
        rst_ni = 1'b1;
        check_at(5);
        chk("idle_after_reset", all_outs(), 32'd0);
        cfg_pat_gen_i = 1'b1;

        // Clean load.
        start_load(0, e);
        push_load(e, 23, 3);
        check_at(e + 1);
        chk("shift_entry_busy", {busy_o, si_read_o}, 32'd3);
        check_at(e + 69);
        chk("done_before_70", {done_o, pat_gen_en_o}, 32'd0);
        check_at(e + 70);
        chk("done_pat_at_70", {done_o, pat_gen_en_o, busy_o}, 32'b110);

        // Reload from DONE.
        check_at(e + 75);
        start_load(0, e);
        push_load(e, 23, 3);
        check_at(e + 1);
        chk("reload_drops_done", {done_o, pat_gen_en_o, busy_o}, 32'b001);
        check_at(e + 70);
        chk("reload_done", {done_o, pat_gen_en_o}, 32'b11);

        // Load with every other SHIFT cycle stalled.
        start_load(1, e);
        push_load(e, 45, 3);
        check_at(e + 44);
        chk("stall_read_44", 32'(si_read_o), 32'd1);
        check_at(e + 45);
        chk("stall_read_45", 32'(si_read_o), 32'd0);
        check_at(e + 46);
        chk("stall_read_46", 32'(si_read_o), 32'd1);
        check_at(e + 136);
        chk("stall_done", {done_o, pat_gen_en_o}, 32'b11);

        // Config drop in DONE returns to IDLE.
        drive_at(e + 140);
        cfg_pat_gen_i = 1'b0;
        check_at(e + 141);
        chk("cfg_drop_done", {done_o, pat_gen_en_o}, 32'd0);
        cfg_pat_gen_i = 1'b1;

        // SI stall timeout.
        start_load(2, e);
        check_at(e + 200);
        chk("no_err_at_200", {err_timeout_o, si_read_o}, 32'b01);
        check_at(e + 201);
        chk("err_at_201", {err_timeout_o, si_read_o, busy_o}, 32'b100);

        // Recovery from ERR.
        start_load(0, e);
        push_load(e, 23, 3);
        check_at(e + 1);
        chk("err_cleared", {err_timeout_o, busy_o}, 32'b01);
        check_at(e + 70);
        chk("recover_done", {done_o, pat_gen_en_o}, 32'b11);

        // Abort after 10 bits of entry 1.
        start_load(0, e);
        push_load(e, 23, 1);
        drive_at(e + 34);
        cfg_pat_gen_i = 1'b0;
        check_at(e + 35);
        chk("abort_idle", {si_read_o, busy_o}, 32'd0);
        drive_at(e + 37);
        cfg_pat_gen_i = 1'b1;
        start_load(0, e);
        push_load(e, 23, 3);
        check_at(e + 70);
        chk("after_abort_done", {done_o, pat_gen_en_o}, 32'b11);

        // Reset mid-load.
        start_load(0, e);
        push_load(e, 23, 1);
        drive_at(e + 40);
        rst_ni = 1'b0;
        check_at(e + 40);
        chk("mid_reset_outputs", all_outs(), 32'd0);
        drive_at(e + 45);
        rst_ni = 1'b1;
        check_at(e + 50);
        chk("stay_idle_after_reset", {si_read_o, busy_o, done_o}, 32'd0);
        start_load(0, e);
        push_load(e, 23, 3);
        check_at(e + 70);
        chk("after_reset_done", {done_o, pat_gen_en_o}, 32'b11);

        check_at(e + 75);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
